// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and grant index.
// Optional per-tenure hold limit compiled in with `define ARB_HOLD_LIMIT_EN.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       preempt_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic       preempt_q, preempt_d;
  logic [2:0] pick;
  logic       found;
  logic       limit_hit;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 1..255");
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;

  // hold_q counts completed grant cycles, so the last allowed cycle sees MAX_HOLD-1
  assign limit_hit = (hold_q == HW'(MAX_HOLD - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Descending scan so the requester closest to ptr_q wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (req_i[ptr_q + 3'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 3'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    preempt_d = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (en_i && found) begin
          idx_d   = pick;
          gnt_d   = 8'b1 << pick;
          state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!en_i || !req_i[idx_q] || limit_hit) begin
          gnt_d     = 8'h00;
          ptr_d     = idx_q + 3'd1;
          state_d   = IDLE;
          preempt_d = en_i && req_i[idx_q];
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_q != '1) hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      ptr_q     <= 3'd0;
      gnt_q     <= 8'h00;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      preempt_q <= preempt_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`endif

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = |gnt_q;
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: per-cycle reference model plus directed literal checks.
// Honours `define ARB_HOLD_LIMIT_EN the same way the design does.
module tb_rr_arbiter_8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .preempt_o  (preempt)
  );

  always #5 clk = ~clk;

  // Reference model: owner/pointer as plain integers, tenure length counted in cycles.
  bit m_valid;
  int m_owner;
  int m_ptr;
  int m_len;
  bit m_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_len   <= 0;
      m_pre   <= 1'b0;
    end else begin
      automatic bit v = m_valid;
      automatic int o = m_owner;
      automatic int p = m_ptr;
      automatic int l = m_len;
      automatic bit pr = 1'b0;
      if (!v) begin
        if (en && req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (!v && req[(p + k) % 8]) begin
              v = 1'b1;
              o = (p + k) % 8;
              l = 1;
            end
          end
        end
      end else if (!en || !req[o]) begin
        v = 1'b0;
        p = (o + 1) % 8;
      end else if (LIMIT && l >= MAXH) begin
        v  = 1'b0;
        p  = (o + 1) % 8;
        pr = 1'b1;
      end else begin
        l = l + 1;
      end
      m_valid <= v;
      m_owner <= o;
      m_ptr   <= p;
      m_len   <= l;
      m_pre   <= pr;
    end
  end

  function automatic logic [7:0] exp_gnt();
    return m_valid ? (8'h01 << m_owner) : 8'h00;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_gnt",       gnt,       exp_gnt());
    cmp("model_gnt_idx",   gnt_idx,   m_owner);
    cmp("model_gnt_valid", gnt_valid, m_valid);
    cmp("model_preempt",   preempt,   m_pre);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with everything requesting
    req = 8'hFF;
    en  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    cmp("reset_gnt",       gnt,       8'h00);
    cmp("reset_gnt_valid", gnt_valid, 0);
    cmp("reset_gnt_idx",   gnt_idx,   0);
    cmp("reset_preempt",   preempt,   0);
    rst_n = 1'b1;
    tick();
    cmp("first_grant", gnt, 8'h01);

    // Rotation 0..7,0 with a one-cycle gap between tenures
    for (int k = 0; k < 9; k++) begin
      cmp("rot_grant", gnt, 8'h01 << (k % 8));
      tick();
      cmp("rot_hold", gnt, 8'h01 << (k % 8));
      req = 8'hFF & ~(8'h01 << (k % 8));
      tick();
      cmp("rot_gap", gnt, 8'h00);
      req = 8'hFF;
      tick();
    end

    // Wrap and skip from ptr=6
    do_reset();
    req = 8'h20;
    tick();
    cmp("ws_owner5", gnt, 8'h20);
    req = 8'h00;
    tick();
    req = 8'h05;
    tick();
    cmp("ws_wrap_to_0", gnt, 8'h01);
    req = 8'h04;
    tick();
    cmp("ws_gap", gnt, 8'h00);
    tick();
    cmp("ws_skip_to_2", gnt, 8'h04);

    // Enable drop on owner 3
    req = 8'h08;
    tick();
    tick();
    cmp("en_owner3", gnt, 8'h08);
    en = 1'b0;
    tick();
    cmp("en_drop", gnt, 8'h00);
    en  = 1'b1;
    req = 8'h18;
    tick();
    cmp("en_ptr4", gnt, 8'h10);

    // Hold limit
    req = 8'h00;
    tick();
    tick();
    req = 8'h02;
    tick();
    cmp("hold_start", gnt, 8'h02);
    if (LIMIT) begin
      for (int c = 1; c < MAXH; c++) begin
        tick();
        cmp("hold_cycle", gnt, 8'h02);
      end
      tick();
      cmp("hold_pre_gnt", gnt, 8'h00);
      cmp("hold_pre_pulse", preempt, 1);
      tick();
      cmp("hold_regrant", gnt, 8'h02);
      cmp("hold_pre_clear", preempt, 0);
    end else begin
      for (int c = 0; c < 20; c++) begin
        tick();
        cmp("hold_unbounded", gnt, 8'h02);
        cmp("hold_no_preempt", preempt, 0);
      end
    end

    // Asynchronous reset mid-tenure
    req = 8'h00;
    tick();
    tick();
    req = 8'h20;
    tick();
    cmp("ar_owner5", gnt, 8'h20);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("ar_async_drop", gnt, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    cmp("ar_regrant", gnt, 8'h20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) req = req ^ (8'h01 << $urandom_range(0, 7));
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        cmp("rand_async_reset", gnt, 8'h00);
        rst_n = 1'b1;
      end
      tick();
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter granting one requester at a time to a shared resource. It delivers the grant both as a registered 3-bit index and as its decoded one-hot form. The block sits in front of any shared datapath whose select lines are decoded 3-to-8. It owns the select index, enforces a one-cycle turnaround between owners, and optionally caps how long one owner may hold the grant.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure, legal range 1..255; used only with the hold limit compiled in.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbiter enable; low forces no grant.
- req  input  8  request vector; bit i is requester i, held high while service is wanted.
- gnt  output  8  one-hot grant, registered; all zero when no grant.
- gnt_idx  output  3  index of the current or last owner, registered.
- gnt_valid  output  1  high while a grant is active; equals |gnt.
- preempt  output  1  one-cycle pulse when a tenure is forcibly ended by the hold limit.

## Operation
- **Reset values:** state IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, preempt=0, rotation pointer ptr=3'd0, hold counter=0.
- **States:** IDLE, GRANT.
- **IDLE, with en=1 and req!=0:**
  - Selects the first set bit of req searching ptr, ptr+1, … mod 8 (wrap 7→0).
  - Loads gnt_idx with that index, sets gnt_valid, loads gnt=1<<idx, clears the hold counter, and moves to GRANT.
- **IDLE, otherwise:** stays in IDLE with gnt=0. gnt_idx keeps its last value.
- **GRANT:** holds gnt_idx and gnt unchanged while en=1 and req[gnt_idx]=1. The hold counter increments each cycle, saturating.
- **Release (GRANT, req[gnt_idx]=0):** gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 8), then IDLE.
- **Disable (GRANT, en=0):** same action as release, including the ptr advance. en has priority over the hold limit.
- **Fairness:** the owner just released is the lowest priority in the next arbitration. Requests from non-owners during GRANT have no effect until IDLE.
- **Simultaneous requests in IDLE:** only the rotation order decides; there is no fixed priority.
- **Invariant:** gnt is always exactly the decode of gnt_idx when gnt_valid=1, and 8'h00 otherwise.

## Timing
- **Grant latency:** req sampled at the rising edge while in IDLE; gnt is high after that same edge (one registered stage).
- **Release latency:** req[owner] low at edge k drives gnt low after edge k.
- **Turnaround:** at least one full cycle with gnt=0 between any two tenures, including back-to-back grants to the same requester.
- **Reset mid-grant:** gnt drops asynchronously on the rst_n assert. Arbitration resumes from ptr=0 at the first edge after release of rst_n.
- **Hold counter width:** $clog2(MAX_HOLD+1) bits.

## Configuration
- **ARB_HOLD_LIMIT_EN defined:**
  - A tenure ends when gnt_valid has been high for MAX_HOLD cycles and req[gnt_idx] is still 1.
  - At the next edge, gnt drops, ptr=gnt_idx+1, and the block returns to IDLE.
  - preempt is high for exactly the one cycle following that edge.
  - If release and the limit coincide, the event is treated as a normal release with preempt=0.
- **ARB_HOLD_LIMIT_EN undefined:**
  - Tenure is unbounded and MAX_HOLD is ignored.
  - The hold counter is not built.
  - preempt is tied to 0.

## Test plan
- **Reset:** assert rst_n=0 with req=8'hFF, en=1 → gnt=8'h00, gnt_valid=0, gnt_idx=0, preempt=0. Release rst_n → gnt=8'h01 after the first edge.
- **Rotation:** req=8'hFF constant, each owner drops its req for one cycle after 2 grant cycles → grant order 0,1,2,…,7,0. A one-cycle gnt=0 gap separates every pair of tenures.
- **Wrap and skip:** ptr=6 (after owner 5 releases), req=8'b0000_0101 → gnt=8'h01 (idx 0), then next tenure gnt=8'h04.
- **Enable:** owner 3 is active and en drops → gnt=0 after the next edge, ptr=4. en=1 with req=8'h08|8'h10 → gnt=8'h10.
- **Hold limit** (ARB_HOLD_LIMIT_EN, MAX_HOLD=4): req=8'h02 held high → gnt=8'h02 for exactly 4 cycles, then 1 cycle gnt=0 with preempt=1, then gnt=8'h02 again. Without the macro, gnt=8'h02 stays high indefinitely and preempt=0.
- **Asynchronous reset mid-tenure:** rst_n pulsed low between edges during a grant to requester 5 → gnt=8'h00 immediately. After release, req=8'h20 → gnt=8'h20.
